// File: rtl/sram_dp_be_if.sv
// sram_dp_be_if: request/response bundle for the dual-port byte-lane SRAM
//   master: drives wr_en/wr_addr/wr_data/wr_be and rd_en/rd_addr, observes rd_data/rd_valid/busy
//   slave : the SRAM side, the reverse directions
interface sram_dp_be_if #(
    parameter int ADDR = 3,
    parameter int DATA = 8,
    parameter int LANE = 4
);
    localparam int NLANE = DATA / LANE;
    logic             wr_en;
    logic [ADDR-1:0]  wr_addr;
    logic [DATA-1:0]  wr_data;
    logic [NLANE-1:0] wr_be;
    logic             rd_en;
    logic [ADDR-1:0]  rd_addr;
    logic [DATA-1:0]  rd_data;
    logic             rd_valid;
    logic             busy;
    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, busy
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/sram_dp_be.sv
// sram_dp_be: simple-dual-port SRAM with lane write enables, registered read and post-reset clear sweep
//   clk, rst : clock and synchronous active-high reset
//   bus      : sram_dp_be_if.slave (write port, read port, rd_data/rd_valid/busy)
module sram_dp_be #(
    parameter int ADDR     = 3,
    parameter int DATA     = 8,
    parameter int LANE     = 4,
    parameter int RDW_MODE = 0
) (
    input logic         clk,
    input logic         rst,
    sram_dp_be_if.slave bus
);
    localparam int DEPTH = 1 << ADDR;
    localparam int NLANE = DATA / LANE;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    logic [ADDR-1:0] ptr;
    logic [DATA-1:0] mem [DEPTH];
    logic [DATA-1:0] merged;
    logic [DATA-1:0] rd_word;
    logic [DATA-1:0] rd_data;
    logic            rd_valid;
    logic            busy;
    logic            wr_fire;

    assign wr_fire = state == RUN && bus.wr_en && |bus.wr_be;

    // merged is the word the array will hold after the write; mode 1 forwards it to a same-address read
    always_comb begin
        merged = mem[bus.wr_addr];
        for (int i = 0; i < NLANE; i++)
            if (bus.wr_be[i]) merged[i*LANE +: LANE] = bus.wr_data[i*LANE +: LANE];
        rd_word = (RDW_MODE == 1 && wr_fire && bus.wr_addr == bus.rd_addr) ? merged : mem[bus.rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) mem[ptr] <= '0;
            else if (wr_fire) mem[bus.wr_addr] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            ptr      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b1;
        end else if (state == INIT) begin
            ptr      <= ptr + 1'b1;
            rd_valid <= 1'b0;
            if (ptr == ADDR'(DEPTH - 1)) begin
                state <= RUN;
                busy  <= 1'b0;
            end
        end else begin
            rd_valid <= bus.rd_en;
            if (bus.rd_en) rd_data <= rd_word;
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid;
    assign bus.busy     = busy;
endmodule

// File: tb/tb_sram_dp_be.sv
// tb_sram_dp_be: directed checks of both read-during-write modes driven with identical stimulus
module tb_sram_dp_be;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] wr_be = '0;
    logic       rd_en = 1'b0;
    logic [2:0] rd_addr = '0;
    int         errors = 0;
    int         checks = 0;
    int         n;
    logic       saw_valid;
    logic [7:0] exp_stream [3];
    logic [2:0] addr_stream [3];

    always #5 clk = ~clk;

    sram_dp_be_if #(.ADDR(3), .DATA(8), .LANE(4)) m0 ();
    sram_dp_be_if #(.ADDR(3), .DATA(8), .LANE(4)) m1 ();

    assign m0.wr_en = wr_en;     assign m1.wr_en = wr_en;
    assign m0.wr_addr = wr_addr; assign m1.wr_addr = wr_addr;
    assign m0.wr_data = wr_data; assign m1.wr_data = wr_data;
    assign m0.wr_be = wr_be;     assign m1.wr_be = wr_be;
    assign m0.rd_en = rd_en;     assign m1.rd_en = rd_en;
    assign m0.rd_addr = rd_addr; assign m1.rd_addr = rd_addr;

    sram_dp_be #(.ADDR(3), .DATA(8), .LANE(4), .RDW_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(m0));
    sram_dp_be #(.ADDR(3), .DATA(8), .LANE(4), .RDW_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(m1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_en = 1'b1; rd_addr = a;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (m0.busy && cnt < 30) begin
            cyc();
            cnt++;
            saw_valid = saw_valid | m0.rd_valid | m1.rd_valid;
        end
    endtask

    initial begin
        cyc(); cyc();
        check("rst_rd_data", m0.rd_data, 8'h00);
        check("rst_rd_valid", m0.rd_valid, 1'b0);
        check("rst_busy", m0.busy, 1'b1);
        // requests held throughout the first sweep must be dropped
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h5A; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 3'd1;
        saw_valid = 1'b0;
        count_busy(n);
        wr_en = 1'b0; rd_en = 1'b0;
        check("sweep1_len", n, 8);
        check("busy_no_valid", saw_valid, 1'b0);
        rd(3'd1);
        check("busy_dropped_wr0", m0.rd_data, 8'h00);
        check("busy_dropped_wr1", m1.rd_data, 8'h00);
        // fill with FF then re-sweep
        for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF, 2'b11);
        rd(3'd6);
        check("fill_ff", m0.rd_data, 8'hFF);
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        check("rst_run_valid", m0.rd_valid, 1'b0);
        check("rst_run_data", m0.rd_data, 8'h00);
        saw_valid = 1'b0;
        count_busy(n);
        check("sweep2_len", n, 8);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            check($sformatf("sweep_rd%0d", i), m0.rd_data, 8'h00);
            check($sformatf("sweep_vld%0d", i), m0.rd_valid, 1'b1);
        end
        cyc();
        check("valid_drops", m0.rd_valid, 1'b0);
        check("data_holds", m0.rd_data, 8'h00);
        // lane enables
        wr(3'd5, 8'hAB, 2'b11);
        wr(3'd5, 8'hCD, 2'b01);
        rd(3'd5);
        check("lane_be", m0.rd_data, 8'hAD);
        // same-address read-during-write, full word
        wr(3'd2, 8'h11, 2'b11);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h22; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 3'd2;
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdw0_old", m0.rd_data, 8'h11);
        check("rdw1_new", m1.rd_data, 8'h22);
        rd(3'd2);
        check("rdw0_after", m0.rd_data, 8'h22);
        check("rdw1_after", m1.rd_data, 8'h22);
        // same-address read-during-write, upper lane only
        wr(3'd2, 8'h11, 2'b11);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h3F; wr_be = 2'b10;
        rd_en = 1'b1; rd_addr = 3'd2;
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rdw1_merged", m1.rd_data, 8'h31);
        check("rdw0_pre", m0.rd_data, 8'h11);
        rd(3'd2);
        check("rdw0_merged_after", m0.rd_data, 8'h31);
        // different addresses on the same edge are independent
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h77; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 3'd5;
        cyc();
        wr_en = 1'b0; rd_en = 1'b0;
        check("indep_rd1", m1.rd_data, 8'hAD);
        // reset on the 4th sweep edge restarts the sweep
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        cyc(); cyc(); cyc();
        check("mid_busy", m0.busy, 1'b1);
        rst = 1'b1; cyc(); rst = 1'b0;
        count_busy(n);
        check("sweep3_len", n, 8);
        for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i), 2'b11);
        addr_stream[0] = 3'd7; addr_stream[1] = 3'd0; addr_stream[2] = 3'd1;
        exp_stream[0] = 8'h17; exp_stream[1] = 8'h10; exp_stream[2] = 8'h11;
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = addr_stream[i];
            cyc();
            check($sformatf("stream_d%0d", i), m0.rd_data, 32'(exp_stream[i]));
            check($sformatf("stream_v%0d", i), m0.rd_valid, 1'b1);
        end
        rd_en = 1'b0;
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_dp_be.md
# sram_dp_be

Parametrised simple-dual-port synchronous SRAM with one write port and one read port sharing a single clock. It is the next generation of the team's single-port SRAM and adds:
- per-lane write enables
- a registered read with a valid strobe
- a selectable read-during-write policy
- a hardware init sweep that clears the array after reset

It sits between datapath blocks that need concurrent read and write access, such as FIFOs, lookup tables and scratchpads.

## Interface
Parameters:
- ADDR, 3, address width; DEPTH = 1 << ADDR words
- DATA, 8, word width in bits
- LANE, 4, bits per write-enable lane; DATA % LANE == 0 required; NLANE = DATA/LANE
- RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new (merged) data

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write request
- wr_addr  in  ADDR  write address
- wr_data  in  DATA  write data
- wr_be  in  NLANE  lane enables; bit i selects wr_data[i*LANE +: LANE]
- rd_en  in  1  read request
- rd_addr  in  ADDR  read address
- rd_data  out  DATA  registered read data; holds last value between reads
- rd_valid  out  1  one-cycle strobe, high when rd_data was updated by an accepted read
- busy  out  1  init sweep in progress; all requests ignored

## Operation
- States: INIT (busy=1) and RUN (busy=0).
- Edge with rst=1:
  - state←INIT, sweep pointer←0, rd_data←0, rd_valid←0, busy←1.
  - The array is not written on this edge.
- INIT with rst=0, each edge:
  - mem[ptr]←0 and ptr←ptr+1.
  - When ptr==DEPTH-1, state←RUN and busy←0 on that same edge.
  - The sweep therefore takes exactly DEPTH edges after reset release.
- In INIT, wr_en and rd_en are dropped, not queued. rd_valid stays 0 and rd_data holds 0.
- RUN write: wr_en=1 updates only the lanes with wr_be[i]=1. wr_be=0 means no write.
- RUN read:
  - rd_en=1 sets rd_data←mem[rd_addr] and rd_valid←1.
  - rd_en=0 sets rd_valid←0 and rd_data holds.
- Read and write to different addresses on the same edge are independent.
- Read and write to the same address on the same edge:
  - RDW_MODE=0: rd_data = the pre-write word.
  - RDW_MODE=1: rd_data = the merged word (enabled lanes from wr_data, other lanes old).
  - In both modes the array holds the merged word afterwards.
- Addresses are full-range; no out-of-range case exists.
- Reset during INIT restarts the sweep from 0.
- Reset during RUN clears the outputs and re-runs the full sweep.

## Timing
- Read latency is 1: a request sampled at edge N gives rd_data/rd_valid valid after edge N, in cycle N+1.
- Back-to-back reads give one result per cycle, so rd_valid stays high continuously.
- Write-to-read latency is 1: a write at edge N is visible to a read sampled at edge N+1. The same-edge case is governed by RDW_MODE.
- busy is high from the first rst edge through exactly DEPTH edges after rst deasserts. The first accepted request is sampled at edge DEPTH+1 after release.
- Reset values: rd_data=0, rd_valid=0, busy=1.

## Test plan
All scenarios use ADDR=3, DATA=8, LANE=4.
- Sweep:
  - Stimulus: fill the array with 0xFF, pulse rst for 2 cycles, then read addresses 0..7.
  - Required: busy is high for exactly 8 edges after release; every read returns 0x00 with rd_valid=1.
- Lane enables:
  - Stimulus: write 0xAB with be=11 to addr 5, then 0xCD with be=01 to addr 5, then read addr 5.
  - Required: rd_data=0xAD one cycle after the read request.
- Read-during-write, RDW_MODE=0:
  - Stimulus: mem[2]=0x11; on the same edge write 0x22 (be=11) and read addr 2.
  - Required: rd_data=0x11, and the next read returns 0x22.
- Read-during-write, RDW_MODE=1:
  - Stimulus: mem[2]=0x11; on the same edge write 0x3F with be=10 and read addr 2.
  - Required: rd_data=0x31.
- Requests during busy:
  - Stimulus: wr_en to addr 1 with 0x5A, and rd_en, issued during the sweep.
  - Required: no rd_valid during the sweep; after busy falls, a read of addr 1 returns 0x00.
- Reset mid-sweep and streaming wrap:
  - Stimulus: assert rst on the 4th sweep edge. Then write 0x10+i to address i, and read addresses 7,0,1 back-to-back.
  - Required: busy stays high for a further 8 edges after release; reads return 0x17, 0x10, 0x11 on consecutive cycles with rd_valid held high.
